// File: rtl/module_serial_subtractor.sv
// Bit-serial two's-complement subtractor.
// Computes A - B one bit per clock, LSB first, with a single borrow flop.
// Uses a start/busy/done handshake. The result registers change only at
// the completion edge, so the previous result stays visible throughout a run.
module module_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Start,
  input  logic [WIDTH-1:0] i_Minuend,
  input  logic [WIDTH-1:0] i_Subtrahend,
  output logic             o_Busy,
  output logic             o_Done,
  output logic [WIDTH-1:0] o_Difference,
  output logic             o_Borrow,
  output logic             o_Overflow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;          // minuend shift register, LSB consumed first
  logic [WIDTH-1:0] b_q;          // subtrahend shift register
  // Only WIDTH-1 bits are stored. The final bit joins them directly at the
  // completion edge, on its way into the result register.
  logic [WIDTH-2:0] diff_q;
  logic             br_q;         // running borrow between bit positions
  logic [CW-1:0]    cnt_q;        // index of the bit being processed
  logic             a_msb_q;      // operand sign bits, kept for the overflow test
  logic             b_msb_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             borrow_q;
  logic             overflow_q;

  logic             bit_d;
  logic             br_d;
  logic [WIDTH-1:0] diff_d;
  logic             last_bit;

  // One full-subtractor cell acting on the current operand LSBs and the borrow.
  always_comb begin
    bit_d    = a_q[0] ^ b_q[0] ^ br_q;
    br_d     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    diff_d   = {bit_d, diff_q};
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  // Control FSM and serial datapath with registered handshake and result outputs.
  // NOTE: every flop here uses <= so all of them see the pre-edge values of the others.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      diff_q     <= '0;
      br_q       <= 1'b0;
      cnt_q      <= '0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (i_Start) begin
            a_q     <= i_Minuend;
            b_q     <= i_Subtrahend;
            a_msb_q <= i_Minuend[WIDTH-1];
            b_msb_q <= i_Subtrahend[WIDTH-1];
            diff_q  <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          diff_q <= diff_d[WIDTH-1:1];
          br_q   <= br_d;
          cnt_q  <= cnt_q + CW'(1);
          if (last_bit) begin
            // All three result fields update together at this edge.
            result_q   <= diff_d;
            borrow_q   <= br_d;
            overflow_q <= (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
            done_q     <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_Busy       = busy_q;
  assign o_Done       = done_q;
  assign o_Difference = result_q;
  assign o_Borrow     = borrow_q;
  assign o_Overflow   = overflow_q;

endmodule

// File: tb/tb_module_serial_subtractor.sv
// Self-checking bench for module_serial_subtractor with WIDTH = 8.
// Expected results are queued when an operation is started and popped by a
// monitor when o_Done is seen. The monitor also checks that the result holds
// steady between completions.
module tb_module_serial_subtractor;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             bor;
    logic             ovf;
  } exp_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] diff;
    logic             bor;
    logic             ovf;
  } vec_t;

  logic             i_Clk;
  logic             i_Rst;
  logic             i_Start;
  logic [WIDTH-1:0] i_Minuend;
  logic [WIDTH-1:0] i_Subtrahend;
  logic             o_Busy;
  logic             o_Done;
  logic [WIDTH-1:0] o_Difference;
  logic             o_Borrow;
  logic             o_Overflow;

  module_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_Start     (i_Start),
    .i_Minuend   (i_Minuend),
    .i_Subtrahend(i_Subtrahend),
    .o_Busy      (o_Busy),
    .o_Done      (o_Done),
    .o_Difference(o_Difference),
    .o_Borrow    (o_Borrow),
    .o_Overflow  (o_Overflow)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   done_cnt = 0;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference arithmetic from integer maths, independent of any bit-serial view.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t r;
    int   sd;
    sd    = int'($signed(a)) - int'($signed(b));
    r.diff = a - b;
    r.bor  = (a < b);
    r.ovf  = (sd > 127) || (sd < -128);
    return r;
  endfunction

  // Monitor: compare on each done pulse, otherwise require the previous result to hold.
  initial begin
    exp_t             e;
    logic [WIDTH-1:0] held_diff;
    logic             held_bor;
    logic             held_ovf;
    held_diff = '0;
    held_bor  = 1'b0;
    held_ovf  = 1'b0;
    forever begin
      @(negedge i_Clk);
      if (i_Rst) begin
        held_diff = '0;
        held_bor  = 1'b0;
        held_ovf  = 1'b0;
      end else if (o_Done) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'(o_Done), 32'(0));
        end else begin
          e = sb_q.pop_front();
          check("difference", 32'(o_Difference), 32'(e.diff));
          check("borrow", 32'(o_Borrow), 32'(e.bor));
          check("overflow", 32'(o_Overflow), 32'(e.ovf));
          held_diff = e.diff;
          held_bor  = e.bor;
          held_ovf  = e.ovf;
        end
      end else begin
        check("result_hold", 32'({o_Difference, o_Borrow, o_Overflow}),
              32'({held_diff, held_bor, held_ovf}));
      end
    end
  end

  // Wait, within a bounded number of cycles, for the next done pulse.
  task automatic wait_done(output int n);
    logic found;
    found = 1'b0;
    n     = 0;
    while (!found && n < 40) begin
      @(negedge i_Clk);
      n++;
      if (o_Done) found = 1'b1;
    end
    check("done_seen", 32'(found), 32'(1));
  endtask

  // One complete operation: start in IDLE, scramble the operands after accept, wait for done.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input exp_t e);
    int n;
    @(posedge i_Clk); #1;
    i_Minuend    = a;
    i_Subtrahend = b;
    i_Start      = 1'b1;
    sb_q.push_back(e);
    @(posedge i_Clk); #1;
    i_Start      = 1'b0;
    i_Minuend    = ~a;
    i_Subtrahend = WIDTH'($urandom);
    wait_done(n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t             vecs[8];
  logic [WIDTH-1:0] a5[4];
  logic [WIDTH-1:0] b5[4];
  exp_t             e;
  int               n;
  int               done_before;

  initial begin
    vecs[0] = '{a: 8'd100, b: 8'd37,  diff: 8'd63,  bor: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 8'd37,  b: 8'd100, diff: 8'hC1,  bor: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'h00,  b: 8'hFF,  diff: 8'h01,  bor: 1'b1, ovf: 1'b0};
    vecs[3] = '{a: 8'h80,  b: 8'h01,  diff: 8'h7F,  bor: 1'b0, ovf: 1'b1};
    vecs[4] = '{a: 8'h7F,  b: 8'hFF,  diff: 8'h80,  bor: 1'b1, ovf: 1'b1};
    vecs[5] = '{a: 8'h5A,  b: 8'h5A,  diff: 8'h00,  bor: 1'b0, ovf: 1'b0};
    vecs[6] = '{a: 8'hFF,  b: 8'h00,  diff: 8'hFF,  bor: 1'b0, ovf: 1'b0};
    vecs[7] = '{a: 8'h00,  b: 8'h01,  diff: 8'hFF,  bor: 1'b1, ovf: 1'b0};
    a5 = '{8'd50, 8'h80, 8'h10, 8'hAA};
    b5 = '{8'd20, 8'h01, 8'h20, 8'h55};

    i_Rst        = 1'b1;
    i_Start      = 1'b0;
    i_Minuend    = '0;
    i_Subtrahend = '0;
    repeat (3) @(posedge i_Clk);
    #1;
    check("rst_busy", 32'(o_Busy), 32'(0));
    check("rst_done", 32'(o_Done), 32'(0));
    check("rst_diff", 32'(o_Difference), 32'(0));
    check("rst_borrow", 32'(o_Borrow), 32'(0));
    check("rst_overflow", 32'(o_Overflow), 32'(0));
    i_Rst = 1'b0;

    // Handshake timing for a single op: busy through edge k+8, done only after edge k+8.
    @(posedge i_Clk); #1;
    i_Minuend    = 8'd100;
    i_Subtrahend = 8'd37;
    i_Start      = 1'b1;
    e = '{diff: 8'd63, bor: 1'b0, ovf: 1'b0};
    sb_q.push_back(e);
    @(posedge i_Clk); #1;
    i_Start = 1'b0;
    for (int cyc = 0; cyc <= 9; cyc++) begin
      @(negedge i_Clk);
      check($sformatf("busy_k+%0d", cyc), 32'(o_Busy), 32'(cyc <= 8));
      check($sformatf("done_k+%0d", cyc), 32'(o_Done), 32'(cyc == 8));
    end

    // Table of arithmetic corner cases.
    for (int i = 0; i < 8; i++) begin
      e = '{diff: vecs[i].diff, bor: vecs[i].bor, ovf: vecs[i].ovf};
      do_op(vecs[i].a, vecs[i].b, e);
    end

    // A few random operands against the integer model.
    for (int i = 0; i < 6; i++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      do_op(ra, rb, model(ra, rb));
    end

    // Start pulses during RUN (edge k+3) and DONE (edge k+9) are ignored.
    done_before = done_cnt;
    @(posedge i_Clk); #1;
    i_Minuend    = 8'd10;
    i_Subtrahend = 8'd3;
    i_Start      = 1'b1;
    e = '{diff: 8'd7, bor: 1'b0, ovf: 1'b0};
    sb_q.push_back(e);
    @(posedge i_Clk); #1;
    i_Minuend    = 8'd200;
    i_Subtrahend = 8'd1;
    for (int ed = 1; ed <= 11; ed++) begin
      i_Start = (ed == 3 || ed == 9);
      @(posedge i_Clk); #1;
    end
    check("ignored_start_dones", 32'(done_cnt - done_before), 32'(1));
    check("ignored_start_idle", 32'(o_Busy), 32'(0));

    // Start held high: a new accept every WIDTH+2 cycles with fresh operands.
    @(posedge i_Clk); #1;
    i_Minuend    = a5[0];
    i_Subtrahend = b5[0];
    i_Start      = 1'b1;
    sb_q.push_back(model(a5[0], b5[0]));
    for (int i = 0; i < 4; i++) begin
      wait_done(n);
      if (i > 0) check("held_start_period", 32'(n), 32'(WIDTH + 2));
      if (i < 3) begin
        i_Minuend    = a5[i+1];
        i_Subtrahend = b5[i+1];
        sb_q.push_back(model(a5[i+1], b5[i+1]));
      end else begin
        i_Start = 1'b0;
      end
    end

    // Asynchronous reset in the middle of an op aborts it without a done pulse.
    @(posedge i_Clk); #1;
    i_Minuend    = 8'hF0;
    i_Subtrahend = 8'h0F;
    i_Start      = 1'b1;
    @(posedge i_Clk); #1;
    i_Start = 1'b0;
    repeat (4) @(posedge i_Clk);
    #2;
    i_Rst = 1'b1;
    #1;
    check("abort_busy", 32'(o_Busy), 32'(0));
    check("abort_done", 32'(o_Done), 32'(0));
    check("abort_diff", 32'(o_Difference), 32'(0));
    check("abort_borrow", 32'(o_Borrow), 32'(0));
    check("abort_overflow", 32'(o_Overflow), 32'(0));
    done_before = done_cnt;
    repeat (2) @(posedge i_Clk);
    #1;
    i_Rst = 1'b0;
    repeat (12) @(negedge i_Clk);
    check("abort_no_done", 32'(done_cnt - done_before), 32'(0));
    check("abort_idle", 32'(o_Busy), 32'(0));
    e = '{diff: 8'd5, bor: 1'b0, ovf: 1'b0};
    do_op(8'd9, 8'd4, e);

    repeat (3) @(negedge i_Clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
